// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, address/data types and the hardwired-zero register index
package rf_pkg;
   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   typedef logic [4:0]          reg_addr_t;
   typedef logic [XLEN_DEF-1:0] xdata_t;
   localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/rf_multiport_if.sv
// rf_multiport_if: decode read ports, writeback write port, issue/flush and scoreboard view
interface rf_multiport_if import rf_pkg::*; #(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD  = 2,
   localparam int AW  = $clog2(NREG)
) ();
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                we;
   logic [AW-1:0]       wa;
   logic [XLEN-1:0]     wd;
   logic                iss_valid;
   logic [AW-1:0]       iss_rd;
   logic                flush;
   logic [NREG-1:0]     busy_vec;
   modport master (output rd_addr, we, wa, wd, iss_valid, iss_rd, flush,
                   input rd_data, rd_busy, busy_vec);
   modport slave  (input rd_addr, we, wa, wd, iss_valid, iss_rd, flush,
                   output rd_data, rd_busy, busy_vec);
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits; issue set beats writeback clear, flush beats both
module rf_scoreboard import rf_pkg::*; #(
   parameter int NREG = NREG_DEF,
   localparam int AW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            iss_valid_i,
   input  logic [AW-1:0]   iss_rd_i,
   input  logic            clr_i,
   input  logic [AW-1:0]   clr_addr_i,
   input  logic            flush_i,
   output logic [NREG-1:0] busy_o
);
   logic [NREG-1:0] busy_d, busy_q;
   always_comb begin
      busy_d = busy_q;
      if (clr_i && clr_addr_i != AW'(ZERO_REG)) busy_d[clr_addr_i] = 1'b0;
      if (iss_valid_i && iss_rd_i != AW'(ZERO_REG)) busy_d[iss_rd_i] = 1'b1;
      if (flush_i) busy_d = '0;
      busy_d[0] = 1'b0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   assign busy_o = busy_q;
endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: NRD-read/1-write register file with x0 = 0 and busy scoreboard.
// Define RF_BYPASS_EN to forward the same-cycle write to matching read ports.
module rf_multiport import rf_pkg::*; #(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD  = 2,
   localparam int AW  = $clog2(NREG)
) (
   input logic           clk,
   input logic           rst_n,
   rf_multiport_if.slave bus
);
   logic [XLEN-1:0] regs_q [1:NREG-1];
   logic [NREG-1:0] busy;
   logic            wr_en;
   assign wr_en = bus.we && bus.wa != AW'(ZERO_REG);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) for (int j = 1; j < NREG; j++) regs_q[j] <= '0;
      else        for (int j = 1; j < NREG; j++) if (wr_en && bus.wa == AW'(j)) regs_q[j] <= bus.wd;
   rf_scoreboard #(.NREG(NREG)) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .iss_valid_i(bus.iss_valid),
      .iss_rd_i   (bus.iss_rd),
      .clr_i      (bus.we),
      .clr_addr_i (bus.wa),
      .flush_i    (bus.flush),
      .busy_o     (busy)
   );
   assign bus.busy_vec = busy;
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rv;
      assign ra = bus.rd_addr[i*AW +: AW];
      always_comb begin
         rv = '0;
         for (int j = 1; j < NREG; j++) if (ra == AW'(j)) rv = regs_q[j];
      end
`ifdef RF_BYPASS_EN
      // Gated by rst_n so a write presented during reset never leaks to the outputs
      logic byp;
      assign byp = rst_n && wr_en && bus.wa == ra;
      assign bus.rd_data[i*XLEN +: XLEN] = byp ? bus.wd : rv;
      assign bus.rd_busy[i] = byp ? (bus.iss_valid && bus.iss_rd == ra) : busy[ra];
`else
      assign bus.rd_data[i*XLEN +: XLEN] = rv;
      assign bus.rd_busy[i] = busy[ra];
`endif
   end
endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed vectors for storage, x0, bypass, scoreboard priority and flush
module tb_rf_multiport;
   import rf_pkg::*;
   logic clk = 0;
   logic rst_n = 0;
   int checks = 0;
   int errors = 0;
   rf_multiport_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();
   rf_multiport #(.XLEN(32), .NREG(32), .NRD(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input xdata_t got, input xdata_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input reg_addr_t a0, input reg_addr_t a1);
      bus.rd_addr = {a1, a0};
      #1;
   endtask

   task automatic wr(input reg_addr_t a, input xdata_t d);
      bus.we = 1; bus.wa = a; bus.wd = d;
      tick();
      bus.we = 0;
   endtask

   task automatic iss(input reg_addr_t a);
      bus.iss_valid = 1; bus.iss_rd = a;
      tick();
      bus.iss_valid = 0;
   endtask

   initial begin
      bus.rd_addr = '0; bus.we = 0; bus.wa = '0; bus.wd = '0;
      bus.iss_valid = 0; bus.iss_rd = '0; bus.flush = 0;
      // writes and issues held during reset must be ignored
      bus.we = 1; bus.wa = 5; bus.wd = 32'h5555_5555; bus.iss_valid = 1; bus.iss_rd = 5;
      rd(5, 5);
      tick();
      chk("rst_rd0", bus.rd_data[31:0], 32'h0);
      chk("rst_busy", bus.busy_vec, 32'h0);
      chk("rst_rdbusy", {30'h0, bus.rd_busy}, 32'h0);
      bus.we = 0; bus.iss_valid = 0;
      rst_n = 1;
      tick();
      rd(5, 5);
      chk("post_rst_x5", bus.rd_data[31:0], 32'h0);

      wr(5, 32'h0000_0011);
      wr(6, 32'h0000_0022);
      rd(5, 6);
      chk("wr_x5", bus.rd_data[31:0], 32'h0000_0011);
      chk("wr_x6", bus.rd_data[63:32], 32'h0000_0022);
      iss(5);
      chk("iss_x5", bus.busy_vec, 32'h0000_0020);
      chk("rdbusy_x5", {31'h0, bus.rd_busy[0]}, 32'h1);
      rst_n = 0;
      #1;
      chk("midrst_x5", bus.rd_data[31:0], 32'h0);
      chk("midrst_x6", bus.rd_data[63:32], 32'h0);
      chk("midrst_busy", bus.busy_vec, 32'h0);
      tick();
      rst_n = 1;
      tick();

      wr(0, 32'hDEAD_BEEF);
      rd(0, 0);
      chk("x0_p0", bus.rd_data[31:0], 32'h0);
      chk("x0_p1", bus.rd_data[63:32], 32'h0);
      iss(0);
      chk("x0_busy", bus.busy_vec, 32'h0);

      wr(7, 32'h1234_5678);
      rd(7, 7);
      chk("x7_p0", bus.rd_data[31:0], 32'h1234_5678);
      chk("x7_p1", bus.rd_data[63:32], 32'h1234_5678);

      iss(3);
      bus.we = 1; bus.wa = 3; bus.wd = 32'hA5A5_A5A5;
      rd(3, 7);
`ifdef RF_BYPASS_EN
      chk("byp_data", bus.rd_data[31:0], 32'hA5A5_A5A5);
      chk("byp_busy", {31'h0, bus.rd_busy[0]}, 32'h0);
`else
      chk("nobyp_data", bus.rd_data[31:0], 32'h0);
      chk("nobyp_busy", {31'h0, bus.rd_busy[0]}, 32'h1);
`endif
      chk("byp_other", bus.rd_data[63:32], 32'h1234_5678);
      tick();
      bus.we = 0;
      chk("x3_after", bus.rd_data[31:0], 32'hA5A5_A5A5);
      chk("x3_clr", bus.busy_vec, 32'h0);

      iss(9);
      chk("x9_set", bus.busy_vec, 32'h0000_0200);
      bus.iss_valid = 1; bus.iss_rd = 9;
      wr(9, 32'h0000_0099);
      bus.iss_valid = 0;
      chk("x9_setwins", bus.busy_vec, 32'h0000_0200);
      wr(9, 32'h0000_009A);
      chk("x9_clr", bus.busy_vec, 32'h0);
      rd(9, 9);
      chk("x9_data", bus.rd_data[31:0], 32'h0000_009A);

      iss(1);
      iss(2);
      iss(31);
      chk("fl_pre", bus.busy_vec, 32'h8000_0006);
      rd(2, 31);
      chk("fl_rdbusy", {30'h0, bus.rd_busy}, 32'h3);
      bus.flush = 1; bus.iss_valid = 1; bus.iss_rd = 4;
      wr(4, 32'h0000_0044);
      bus.flush = 0; bus.iss_valid = 0;
      chk("fl_busy", bus.busy_vec, 32'h0);
      rd(4, 4);
      chk("fl_wr", bus.rd_data[31:0], 32'h0000_0044);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
